// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory wait-state/timeout FSM, branch flush, load-use/RAW stall, forwarding.
// Define PIPELINE_CTRL_FORWARDING_EN to build in EX forwarding; otherwise RAW hazards stall in ID.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        memwb_bubble,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic [31:0] stall_cycles,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic mem_stall;
  logic load_use;
  logic raw_stall;

  assign load_use = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

`ifdef PIPELINE_CTRL_FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic mem_we,
                                         input logic [4:0] mem_dst, input logic wb_we,
                                         input logic [4:0] wb_dst);
    if (mem_we && (mem_dst != 5'd0) && (mem_dst == rs)) return 2'b10;
    if (wb_we && (wb_dst != 5'd0) && (wb_dst == rs))    return 2'b01;
    return 2'b00;
  endfunction

  logic unused_fwd;
  assign unused_fwd = ex_regwrite;
  assign forward_a  = fwd_sel(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
  assign forward_b  = fwd_sel(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
  assign raw_stall  = 1'b0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_rs1, ex_rs2, wb_rd, wb_regwrite};
  assign forward_a  = 2'b00;
  assign forward_b  = 2'b00;
  // Without forwarding, any producer still in EX or MEM must drain before ID reads it.
  assign raw_stall  = ((id_rs1 != 5'd0) &&
                       ((ex_regwrite && (ex_rd == id_rs1)) || (mem_regwrite && (mem_rd == id_rs1)))) ||
                      ((id_rs2 != 5'd0) &&
                       ((ex_regwrite && (ex_rd == id_rs2)) || (mem_regwrite && (mem_rd == id_rs2))));
`endif

  // Gated by reset so asserting reset releases a memory stall immediately.
  assign mem_stall = reset_n && dmem_req && !dmem_ready;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    case (state_q)
      TIMEOUT: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
      end
      default: begin
        if (mem_stall) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          if (state_q != MEM_WAIT) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = 4'd1;
          end else if (wait_cnt_q == 4'd15) begin
            state_d    = TIMEOUT;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = 4'd0;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use || raw_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
    endcase
  end

  assign stall_cycles_d = (!pc_write && (stall_cycles_q != 32'hFFFF_FFFF)) ?
                          stall_cycles_q + 32'd1 : stall_cycles_q;

  // Falling edge keeps this block in step with the pipeline registers.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= 4'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign mem_timeout  = (state_q == TIMEOUT);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; expectations queued on drive, checked on the rising edge.
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        ex_memread, ex_regwrite, mem_regwrite, wb_regwrite;
  logic        branch_taken, dmem_req, dmem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, idex_write, exmem_write, memwb_bubble;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] stall_cycles;
  logic        mem_timeout;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .idex_write(idex_write), .exmem_write(exmem_write), .memwb_bubble(memwb_bubble),
    .forward_a(forward_a), .forward_b(forward_b), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  // {pc_write, ifid_write, ifid_flush, idex_flush, idex_write, exmem_write, memwb_bubble, fa, fb, timeout}
  wire [11:0] obs = {pc_write, ifid_write, ifid_flush, idex_flush, idex_write, exmem_write,
                     memwb_bubble, forward_a, forward_b, mem_timeout};

  localparam logic [11:0] E_RUN = 12'b1100_1100_0000;
  localparam logic [11:0] E_MEM = 12'b0000_0010_0000;
  localparam logic [11:0] E_TMO = 12'b0000_0010_0001;
  localparam logic [11:0] E_BR  = 12'b1111_1100_0000;
  localparam logic [11:0] E_LU  = 12'b0001_1100_0000;
`ifdef PIPELINE_CTRL_FORWARDING_EN
  localparam logic [11:0] E_RAW = E_RUN;
  localparam logic [11:0] FA10 = 12'h010, FA01 = 12'h008, FB10 = 12'h004, FB01 = 12'h002;
`else
  localparam logic [11:0] E_RAW = E_LU;
  localparam logic [11:0] FA10 = 12'h000, FA01 = 12'h000, FB10 = 12'h000, FB01 = 12'h000;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [11:0] sb_q[$];

  task automatic step(input logic [11:0] e, input string tag);
    logic [11:0] want;
    sb_q.push_back(e);
    @(posedge clk);
    want = sb_q.pop_front();
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: outputs %b, expected %b", tag, obs, want);
    end
    vectors++;
    assert (stall_cycles === exp_stall) else begin
      miscompares++;
      $error("FAIL %s_cnt: stall_cycles %h, expected %h", tag, stall_cycles, exp_stall);
    end
    @(negedge clk);
    if (reset_n && !want[11] && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {ex_memread, ex_regwrite, mem_regwrite, wb_regwrite} = '0;
    {branch_taken, dmem_req, dmem_ready} = '0;
    @(negedge clk); #1;
    step(E_RUN, "reset_idle");
    dmem_req = 1'b1;
    step(E_RUN, "reset_memreq");
    dmem_req = 1'b0; reset_n = 1'b1;
    step(E_RUN, "idle");

    // three wait states then ready
    dmem_req = 1'b1;
    repeat (3) step(E_MEM, "ws_stall");
    dmem_ready = 1'b1;
    step(E_RUN, "ws_release");
    dmem_req = 1'b0; dmem_ready = 1'b0;
    step(E_RUN, "ws_after");

    dmem_req = 1'b1; branch_taken = 1'b1;
    step(E_MEM, "br_in_stall_run");
    step(E_MEM, "br_in_stall_wait");
    branch_taken = 1'b0; dmem_ready = 1'b1;
    step(E_RUN, "br_release");
    dmem_req = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b1;
    step(E_BR, "branch");
    branch_taken = 1'b0;

    ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
    step(E_LU, "lu_rs2");
    id_rs2 = 5'd0; id_rs1 = 5'd5;
    step(E_LU, "lu_rs1");
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd5;
    step(E_RUN, "lu_x0");
    id_rs2 = 5'd0;
    step(E_RUN, "lu_x0_both");
    ex_rd = 5'd5; id_rs2 = 5'd5; branch_taken = 1'b1;
    step(E_BR, "br_lu");
    branch_taken = 1'b0; ex_memread = 1'b0;
    step(E_RUN, "no_memread");

    ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd0;
    step(E_RAW, "raw_ex");
    ex_regwrite = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd9; id_rs2 = 5'd9;
    step(E_RAW, "raw_mem");
    mem_rd = 5'd0; id_rs2 = 5'd0;
    step(E_RUN, "raw_x0");
    mem_regwrite = 1'b0; wb_regwrite = 1'b1; wb_rd = 5'd3; id_rs1 = 5'd3;
    step(E_RUN, "raw_wb_none");
    id_rs1 = 5'd0;

    mem_regwrite = 1'b1; mem_rd = 5'd7; wb_regwrite = 1'b1; wb_rd = 5'd7; ex_rs1 = 5'd7;
    step(E_RUN | FA10, "fwd_mem_prio");
    ex_rs2 = 5'd7;
    step(E_RUN | FA10 | FB10, "fwd_both");
    mem_regwrite = 1'b0;
    step(E_RUN | FA01 | FB01, "fwd_wb");
    ex_rs1 = 5'd3; ex_rs2 = 5'd0;
    step(E_RUN, "fwd_nomatch");
    mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0;
    step(E_RUN, "fwd_x0");
    {mem_regwrite, wb_regwrite} = '0;

    // 16 stalled cycles lead to TIMEOUT, which only reset leaves
    dmem_req = 1'b1;
    repeat (16) step(E_MEM, "to_stall");
    repeat (4) step(E_TMO, "to_hold");
    dmem_ready = 1'b1;
    step(E_TMO, "to_sticky_ready");
    dmem_req = 1'b0;
    step(E_TMO, "to_sticky_idle");

    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles_q;
    exp_stall = 32'hFFFF_FFFD;
    repeat (4) step(E_TMO, "sat");

    dmem_req = 1'b1; dmem_ready = 1'b0; reset_n = 1'b0; exp_stall = 32'd0;
    step(E_RUN, "rst_in_tmo");
    reset_n = 1'b1; dmem_req = 1'b0;
    step(E_RUN, "rst_after");

    dmem_req = 1'b1;
    step(E_MEM, "mw_a");
    step(E_MEM, "mw_b");
    reset_n = 1'b0; exp_stall = 32'd0;
    step(E_RUN, "rst_in_wait");
    reset_n = 1'b1; dmem_req = 1'b0;
    step(E_RUN, "final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk input 1, reset_n input 1.
REQ-002 Ports, one per line, as name  direction  width  meaning:
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
- ex_rd  in  5  destination register in EX
- ex_memread, ex_regwrite  in  1 each  control bits of the instruction in EX
- mem_rd  in  5  destination register in MEM
- mem_regwrite  in  1  control bit of the instruction in MEM
- wb_rd  in  5  destination register in WB
- wb_regwrite  in  1  control bit of the instruction in WB
- branch_taken  in  1  branch resolved taken in EX
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, ifid_write  out  1 each  PC and IF/ID load enables
- ifid_flush, idex_flush  out  1 each  zero the control bits captured by IF/ID and ID/EX
- idex_write, exmem_write  out  1 each  ID/EX and EX/MEM load enables
- memwb_bubble  out  1  MEM/WB captures regwrite=0 and memtoreg=0
- forward_a, forward_b  out  2 each  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB
- stall_cycles  out  32  performance counter
- mem_timeout  out  1  sticky error flag

Function
REQ-003 State SHALL update on the falling edge of clk, matching the pipeline registers. Control outputs SHALL be combinational from state and inputs.
REQ-004 The FSM SHALL have three states: RUN, MEM_WAIT and TIMEOUT.
REQ-005 In RUN with no hazard, the block SHALL drive all write enables to 1, both flushes to 0 and memwb_bubble to 0.
REQ-006 A memory stall SHALL be detected when dmem_req=1 and dmem_ready=0 in RUN or MEM_WAIT.
- Response: pc_write, ifid_write, idex_write and exmem_write driven to 0; memwb_bubble driven to 1.
- Next state: MEM_WAIT.
REQ-007 In MEM_WAIT, when dmem_ready=1 the block SHALL release all stalls in that same cycle, drive memwb_bubble=0 and return to RUN.
REQ-008 wait_cnt (4-bit) SHALL be set to 1 on entry to MEM_WAIT and increment each further stalled cycle.
- If wait_cnt=15 and dmem_ready=0, the next state SHALL be TIMEOUT.
REQ-009 In TIMEOUT, the block SHALL drive all write enables to 0, memwb_bubble to 1 and mem_timeout to 1.
- TIMEOUT SHALL be left only by reset.
REQ-010 A taken branch in RUN with no memory stall SHALL drive ifid_flush=1 and idex_flush=1 for one cycle, with pc_write=1.
REQ-011 A load-use hazard SHALL be ex_memread=1, ex_rd≠0, and ex_rd equal to id_rs1 or id_rs2.
- Response: pc_write=0, ifid_write=0, idex_flush=1 for one cycle.
REQ-012 Hazard priority SHALL be: memory stall, then branch flush, then load-use or RAW stall.
- A branch_taken during a memory stall SHALL be ignored; EX is frozen and the branch is re-presented.
- Branch and load-use together SHALL produce the flush only.
REQ-013 stall_cycles SHALL increment on every clock edge where pc_write=0, saturating at 0xFFFFFFFF.
REQ-014 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-015 When reset_n=0, the block SHALL asynchronously force state=RUN, wait_cnt=0, stall_cycles=0 and mem_timeout=0.
REQ-016 While in reset, combinational outputs SHALL follow REQ-005, REQ-010, REQ-011 and REQ-018/019 as for RUN.
- Reset asserted mid-MEM_WAIT or in TIMEOUT SHALL release all stalls immediately.

Configuration
REQ-017 The macro PIPELINE_CTRL_FORWARDING_EN SHALL select whether forwarding is compiled in.
REQ-018 With PIPELINE_CTRL_FORWARDING_EN defined:
- forward_a=10 when mem_regwrite=1, mem_rd≠0 and mem_rd=ex_rs1.
- Else forward_a=01 when wb_regwrite=1, wb_rd≠0 and wb_rd=ex_rs1.
- Else forward_a=00.
- forward_b SHALL be generated identically from ex_rs2.
REQ-019 With PIPELINE_CTRL_FORWARDING_EN undefined:
- forward_a and forward_b SHALL be tied to 00.
- Beyond load-use, a RAW stall (response per REQ-011) SHALL apply whenever id_rs1 or id_rs2 (nonzero) matches ex_rd with ex_regwrite=1, or mem_rd with mem_regwrite=1.

Verification
REQ-020 Wait-state access: dmem_req=1, dmem_ready low for 3 cycles, then high -> exmem_write=0 and memwb_bubble=1 for exactly 3 cycles, RUN on the 4th cycle, stall_cycles=3.
REQ-021 Timeout: dmem_ready held low 20 cycles -> mem_timeout=1 after 16 stalled cycles and stays 1; reset_n pulse -> mem_timeout=0, state RUN.
REQ-022 Load-use: ex_memread=1, ex_rd=5, id_rs2=5 -> pc_write=0 and idex_flush=1 for one cycle; repeated with ex_rd=0 -> no stall.
REQ-023 Simultaneous events: branch_taken=1 with a load-use match -> ifid_flush=1, idex_flush=1, pc_write=1; branch_taken=1 during a memory stall -> no flush.
REQ-024 Forwarding (macro defined): mem_rd=wb_rd=7, both regwrite=1, ex_rs1=7 -> forward_a=10. Macro undefined with ex_rd=7, ex_regwrite=1, id_rs1=7 -> forward_a=00 and a one-cycle stall.
REQ-025 Counter saturation: stall_cycles preloaded near 0xFFFFFFFF via a long stall -> holds at 0xFFFFFFFF without wrapping.
